mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single memory port with a wait timeout.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data wins ties.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic              busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT_I = 2'd1;
    localparam logic [1:0] WAIT_D = 2'd2;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0] state;
    logic       last_grant;
    logic [7:0] wait_cnt;
    logic       pick_d;

    // Winner selection among requests present in IDLE.
    always_comb begin
        pick_d = d_req;
`ifdef MEM_ARB_RR_EN
        if (if_req && d_req) begin
            pick_d = (last_grant == GRANT_I);
        end
`endif
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            wait_cnt   <= 8'd0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            d_gnt      <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            err        <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        wait_cnt   <= 8'd0;
                        mem_req    <= 1'b1;
                        last_grant <= pick_d ? GRANT_D : GRANT_I;
                        if (pick_d) begin
                            state     <= WAIT_D;
                            d_gnt     <= 1'b1;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            state     <= WAIT_I;
                            if_gnt    <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                WAIT_I, WAIT_D: begin
                    // A ready strobe in the terminal-count cycle still completes normally.
                    if (mem_ready || (wait_cnt == TIMEOUT_CNT)) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        wait_cnt  <= 8'd0;
                        err       <= !mem_ready;
                        if (state == WAIT_I) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_ready ? mem_rdata : '0;
                        end else begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= (mem_ready && !mem_we) ? mem_rdata : '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
